// File: rtl/intr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intr_pkg
// Description : Shared constants for the prioritised interrupt controller:
//               register map addresses and the default source count.
//               Optional feature macro: INTR_EDGE_EN (EDGE_CFG register).
// Revision    : 1.0 - initial release
// ============================================================================
package intr_pkg;

  // Default number of interrupt request lines
  localparam int NUM_SRC_DEFAULT = 8;

  // Register bus address type
  typedef logic [2:0] reg_addr_t;

  // Register map
  localparam reg_addr_t ADDR_ENABLE  = 3'd0;
  localparam reg_addr_t ADDR_PENDING = 3'd1;
  localparam reg_addr_t ADDR_RAW     = 3'd2;
  localparam reg_addr_t ADDR_VECTOR  = 3'd3;
  localparam reg_addr_t ADDR_EDGE    = 3'd4;

endpackage
`default_nettype wire

// File: rtl/intr_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : intr_prio_enc
// Description : Combinational fixed-priority encoder. Lowest set index wins;
//               index is 0 when no request is present.
// Revision    : 1.0 - initial release
// ============================================================================
module intr_prio_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] i_req,
  output logic         o_valid,
  output logic [W-1:0] o_idx
);

  // Scan from the top down so the lowest set bit is the last to overwrite
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/intr_controller.sv
`default_nettype none
// ============================================================================
// Module      : intr_controller
// Description : Prioritised interrupt controller. Latches request lines into
//               pending bits, masks them with ENABLE and presents the lowest
//               active index on a registered irq/irq_id pair. Small register
//               bus for configuration. Scan ports are placeholders for DFT.
//               Optional feature macro: INTR_EDGE_EN - when defined, adds the
//               EDGE_CFG register (addr 4) and per-source edge detection.
// Revision    : 1.0 - initial release
// ============================================================================
module intr_controller
  import intr_pkg::*;
#(
  parameter  int NUM_SRC = NUM_SRC_DEFAULT,
  localparam int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [2:0]         addr,
  input  logic [NUM_SRC-1:0] wdata,
  output logic [NUM_SRC-1:0] rdata,
  input  logic               scan_in0,
  input  logic               scan_in1,
  input  logic               scan_in2,
  input  logic               scan_in3,
  input  logic               scan_in4,
  input  logic               scan_enable,
  input  logic               test_mode,
  output logic               scan_out0,
  output logic               scan_out1,
  output logic               scan_out2,
  output logic               scan_out3,
  output logic               scan_out4
);

  // State flops and their next-state values
  logic [NUM_SRC-1:0] src_q,     src_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q,  enable_d;
  logic               irq_q,     irq_d;
  logic [ID_W-1:0]    irq_id_q,  irq_id_d;
  logic [NUM_SRC-1:0] rdata_q,   rdata_d;
`ifdef INTR_EDGE_EN
  logic [NUM_SRC-1:0] src_qq_q,  src_qq_d;
  logic [NUM_SRC-1:0] edge_cfg_q, edge_cfg_d;
`endif

  // Combinational helpers
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_ack_clr;
  logic [NUM_SRC-1:0] w_w1c_clr;
  logic [NUM_SRC-1:0] w_active;
  logic [NUM_SRC-1:0] w_vector;
  logic               w_valid;
  logic [ID_W-1:0]    w_idx;

  assign w_active = pending_q & enable_q;

  intr_prio_enc #(
    .N (NUM_SRC),
    .W (ID_W)
  ) u_prio_enc (
    .i_req   (w_active),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  // Pending-set sources: level mode uses src_q directly, edge mode its rise
  always_comb begin
`ifdef INTR_EDGE_EN
    w_set = (src_q & ~edge_cfg_q) | (src_q & ~src_qq_q & edge_cfg_q);
`else
    w_set = src_q;
`endif
  end

  // Clear sources: CPU acknowledge of the presented ID, and W1C writes
  always_comb begin
    w_ack_clr = '0;
    if (irq_ack && irq_q) begin
      w_ack_clr = NUM_SRC'(1) << irq_id_q;
    end
    w_w1c_clr = '0;
    if (wr_en && (addr == ADDR_PENDING)) begin
      w_w1c_clr = wdata;
    end
  end

  // VECTOR register image: {irq, irq_id} zero-extended
  always_comb begin
    w_vector             = '0;
    w_vector[ID_W-1:0]   = irq_id_q;
    w_vector[ID_W]       = irq_q;
  end

  // Next-state logic: input pipeline, pending, config writes, arbitration, read
  always_comb begin
    src_d     = src;
    // Set is applied after clear so a simultaneous request is never lost
    pending_d = (pending_q & ~(w_ack_clr | w_w1c_clr)) | w_set;
    enable_d  = enable_q;
    if (wr_en && (addr == ADDR_ENABLE)) begin
      enable_d = wdata;
    end
`ifdef INTR_EDGE_EN
    src_qq_d   = src_q;
    edge_cfg_d = edge_cfg_q;
    if (wr_en && (addr == ADDR_EDGE)) begin
      edge_cfg_d = wdata;
    end
`endif
    irq_d    = w_valid;
    irq_id_d = w_idx;
    // Read mux sees pre-write register values
    rdata_d  = rdata_q;
    if (rd_en) begin
      case (addr)
        ADDR_ENABLE:  rdata_d = enable_q;
        ADDR_PENDING: rdata_d = pending_q;
        ADDR_RAW:     rdata_d = src_q;
        ADDR_VECTOR:  rdata_d = w_vector;
`ifdef INTR_EDGE_EN
        ADDR_EDGE:    rdata_d = edge_cfg_q;
`endif
        default:      rdata_d = '0;
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      src_q      <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      irq_q      <= 1'b0;
      irq_id_q   <= '0;
      rdata_q    <= '0;
`ifdef INTR_EDGE_EN
      src_qq_q   <= '0;
      edge_cfg_q <= '0;
`endif
    end else begin
      src_q      <= src_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      irq_q      <= irq_d;
      irq_id_q   <= irq_id_d;
      rdata_q    <= rdata_d;
`ifdef INTR_EDGE_EN
      src_qq_q   <= src_qq_d;
      edge_cfg_q <= edge_cfg_d;
`endif
    end
  end

  assign irq    = irq_q;
  assign irq_id = irq_id_q;
  assign rdata  = rdata_q;

  // Scan chains are stitched at DFT insertion; functional view drives 0
  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  logic unused_scan;
  assign unused_scan = &{1'b0, scan_in0, scan_in1, scan_in2, scan_in3,
                         scan_in4, scan_enable, test_mode};

endmodule
`default_nettype wire

// File: tb/tb_intr_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_intr_controller
// Description : Directed self-checking bench for intr_controller with
//               hand-computed expectations. Edge-mode checks are compiled
//               in when INTR_EDGE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intr_controller;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_SRC-1:0] src;
  logic               irq;
  logic [ID_W-1:0]    irq_id;
  logic               irq_ack;
  logic               wr_en;
  logic               rd_en;
  logic [2:0]         addr;
  logic [NUM_SRC-1:0] wdata;
  logic [NUM_SRC-1:0] rdata;
  logic               scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
  logic               scan_enable, test_mode;
  logic               scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

  int n_checks = 0;
  int n_fail   = 0;

  intr_controller #(.NUM_SRC(NUM_SRC)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .src         (src),
    .irq         (irq),
    .irq_id      (irq_id),
    .irq_ack     (irq_ack),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .scan_in0    (scan_in0),
    .scan_in1    (scan_in1),
    .scan_in2    (scan_in2),
    .scan_in3    (scan_in3),
    .scan_in4    (scan_in4),
    .scan_enable (scan_enable),
    .test_mode   (test_mode),
    .scan_out0   (scan_out0),
    .scan_out1   (scan_out1),
    .scan_out2   (scan_out2),
    .scan_out3   (scan_out3),
    .scan_out4   (scan_out4)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled 1 ns after it
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [NUM_SRC-1:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    tick();
    wr_en = 1'b0; wdata = '0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [NUM_SRC-1:0] d);
    rd_en = 1'b1; addr = a;
    tick();
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  logic [NUM_SRC-1:0] rd;

  initial begin
    reset = 1'b0; src = '0; irq_ack = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    addr = '0; wdata = '0;
    scan_in0 = 1'b1; scan_in1 = 1'b1; scan_in2 = 1'b1; scan_in3 = 1'b1;
    scan_in4 = 1'b1; scan_enable = 1'b1; test_mode = 1'b1;

    // Reset state
    tick(2);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_irq_id", {29'd0, irq_id}, 32'd0);
    check("rst_scan_out", {27'd0, scan_out4, scan_out3, scan_out2, scan_out1, scan_out0}, 32'd0);
    scan_enable = 1'b0; test_mode = 1'b0;
    reset = 1'b1;
    reg_read(3'd0, rd); check("rst_enable", {24'd0, rd}, 32'h00);
    reg_read(3'd1, rd); check("rst_pending", {24'd0, rd}, 32'h00);
    reg_read(3'd4, rd); check("rst_edge", {24'd0, rd}, 32'h00);

    // Single level source: irq exactly 3 edges after src rises
    reg_write(3'd0, 8'h08);
    reg_read(3'd0, rd); check("enable_rb", {24'd0, rd}, 32'h08);
    src = 8'h08;
    tick(2);
    check("lvl_irq_e2", {31'd0, irq}, 32'd0);
    tick();
    check("lvl_irq_e3", {31'd0, irq}, 32'd1);
    check("lvl_id", {29'd0, irq_id}, 32'd3);
    reg_read(3'd3, rd); check("vector", {24'd0, rd}, 32'h0B);
    src = 8'h00;
    tick();
    ack();
    check("ack_irq_e1", {31'd0, irq}, 32'd1);
    tick();
    check("ack_irq_e2", {31'd0, irq}, 32'd0);

    // Priority between sources 2 and 5
    reg_write(3'd0, 8'hFF);
    src = 8'h24;
    tick(3);
    check("prio_irq", {31'd0, irq}, 32'd1);
    check("prio_id2", {29'd0, irq_id}, 32'd2);
    src = 8'h20;
    tick();
    ack();
    tick();
    check("prio_id5", {29'd0, irq_id}, 32'd5);
    check("prio_irq5", {31'd0, irq}, 32'd1);
    src = 8'h00;
    tick();
    ack();
    tick();
    check("prio_done", {31'd0, irq}, 32'd0);

    // Mask: pending latched even when disabled
    reg_write(3'd0, 8'h00);
    src = 8'h02;
    tick(3);
    check("mask_irq", {31'd0, irq}, 32'd0);
    reg_read(3'd1, rd); check("mask_pending", {24'd0, rd}, 32'h02);
    reg_read(3'd2, rd); check("raw", {24'd0, rd}, 32'h02);
    reg_write(3'd0, 8'h02);
    check("unmask_e1", {31'd0, irq}, 32'd0);
    tick();
    check("unmask_irq", {31'd0, irq}, 32'd1);
    check("unmask_id", {29'd0, irq_id}, 32'd1);
    src = 8'h00;
    tick();
    reg_write(3'd1, 8'h02);
    tick();
    check("w1c_irq", {31'd0, irq}, 32'd0);
    reg_read(3'd1, rd); check("w1c_pending", {24'd0, rd}, 32'h00);

    // W1C against a held level source: set wins
    src = 8'h01;
    tick(2);
    reg_write(3'd1, 8'h01);
    reg_read(3'd1, rd); check("set_wins", {24'd0, rd}, 32'h01);

    // Same-cycle read and write of ENABLE returns the old value
    rd_en = 1'b1; wr_en = 1'b1; addr = 3'd0; wdata = 8'h55;
    tick();
    rd_en = 1'b0; wr_en = 1'b0; wdata = '0;
    check("rw_same", {24'd0, rdata}, 32'h02);
    reg_read(3'd0, rd); check("rw_after", {24'd0, rd}, 32'h55);

    // Unmapped address: writes ignored, reads 0
    reg_write(3'd5, 8'hFF);
    reg_read(3'd5, rd); check("unmapped", {24'd0, rd}, 32'h00);
`ifndef INTR_EDGE_EN
    reg_write(3'd4, 8'hFF);
    reg_read(3'd4, rd); check("no_edge_reg", {24'd0, rd}, 32'h00);
`endif

    // Reset mid-operation: source 0 pending and enabled
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    check("pre_rst_id", {29'd0, irq_id}, 32'd0);
    src = 8'h00;
    reset = 1'b0;
    tick();
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b1;
    reg_read(3'd0, rd); check("mid_rst_enable", {24'd0, rd}, 32'h00);
    reg_read(3'd1, rd); check("mid_rst_pending", {24'd0, rd}, 32'h00);

`ifdef INTR_EDGE_EN
    // Edge mode: a held-high source pends once
    reg_write(3'd4, 8'h01);
    reg_read(3'd4, rd); check("edge_cfg_rb", {24'd0, rd}, 32'h01);
    reg_write(3'd0, 8'h01);
    src = 8'h01;
    tick(3);
    check("edge_irq", {31'd0, irq}, 32'd1);
    check("edge_id", {29'd0, irq_id}, 32'd0);
    ack();
    tick();
    check("edge_ack", {31'd0, irq}, 32'd0);
    tick(3);
    check("edge_hold", {31'd0, irq}, 32'd0);
    reg_read(3'd1, rd); check("edge_pending", {24'd0, rd}, 32'h00);
    src = 8'h00;
    tick(2);
    src = 8'h01;
    tick(3);
    check("edge_rearm", {31'd0, irq}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
